segre_writeback_arbiter: RTL and testbench



---
 rtl/segre_pkg.sv | 12 +
 rtl/segre_writeback_arbiter.sv | 148 ++++++++++++++
 tb/tb_segre_writeback_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/segre_pkg.sv
// Shared core widths and the write-back entry payload.
package segre_pkg;

    localparam int unsigned REG_SIZE  = 5;
    localparam int unsigned WORD_SIZE = 32;

    typedef struct packed {
        logic [REG_SIZE-1:0]  waddr;
        logic [WORD_SIZE-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/segre_writeback_arbiter.sv
// Buffers ALU and MEM results in per-source FIFOs and drives the single register-file write port.
// Optional statistics counters are enabled by defining SEGRE_WB_STATS_EN.
module segre_writeback_arbiter
    import segre_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned NUM_REGS   = 2**REG_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 alu_valid_i,
    output logic                 alu_ready_o,
    input  logic [REG_SIZE-1:0]  alu_waddr_i,
    input  logic [WORD_SIZE-1:0] alu_data_i,
    input  logic                 mem_valid_i,
    output logic                 mem_ready_o,
    input  logic [REG_SIZE-1:0]  mem_waddr_i,
    input  logic [WORD_SIZE-1:0] mem_data_i,
    output logic                 rf_we_o,
    output logic [REG_SIZE-1:0]  rf_waddr_o,
    output logic [WORD_SIZE-1:0] rf_data_w_o,
    output logic [NUM_REGS-1:0]  pending_o
`ifdef SEGRE_WB_STATS_EN
    ,
    output logic [31:0]          stat_writes_o,
    output logic [31:0]          stat_conflicts_o
`endif
);

    localparam int unsigned NSRC    = 2;
    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_MEM = 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STV_W   = $clog2(STARVE_MAX + 1);

    logic [NSRC-1:0]     in_valid;
    logic [NSRC-1:0]     in_ready;
    logic [NSRC-1:0]     push;
    logic [NSRC-1:0]     pop;
    logic [NSRC-1:0]     not_empty;
    wb_entry_t           in_entry  [NSRC];
    wb_entry_t           head      [NSRC];
    logic [NUM_REGS-1:0] pend_src  [NSRC];

    logic                grant_alu;
    logic                grant_mem;
    wb_entry_t           grant_entry;
    logic [STV_W-1:0]    starve_q;

    assign in_valid = {mem_valid_i, alu_valid_i};
    assign in_entry[SRC_ALU] = '{waddr: alu_waddr_i, data: alu_data_i};
    assign in_entry[SRC_MEM] = '{waddr: mem_waddr_i, data: mem_data_i};
    assign pop = {grant_mem, grant_alu};

    assign alu_ready_o = in_ready[SRC_ALU];
    assign mem_ready_o = in_ready[SRC_MEM];

    for (genvar s = 0; s < NSRC; s++) begin : g_fifo
        wb_entry_t           mem_q [FIFO_DEPTH];
        logic [PTR_W-1:0]    wr_ptr_q;
        logic [PTR_W-1:0]    rd_ptr_q;
        logic [CNT_W-1:0]    cnt_q;
        logic [NUM_REGS-1:0] pend;

        // Ready depends only on start-of-cycle occupancy; x0 results are acknowledged but dropped.
        assign in_ready[s]  = rsn_i && (cnt_q != CNT_W'(FIFO_DEPTH));
        assign push[s]      = in_valid[s] && in_ready[s] && (in_entry[s].waddr != '0);
        assign not_empty[s] = (cnt_q != '0);
        assign head[s]      = mem_q[rd_ptr_q];
        assign pend_src[s]  = pend;

        always_ff @(posedge clk_i) begin
            if (!rsn_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push[s]) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop[s])  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                if (push[s] && !pop[s])      cnt_q <= cnt_q + CNT_W'(1);
                else if (!push[s] && pop[s]) cnt_q <= cnt_q - CNT_W'(1);
            end
        end

        always_ff @(posedge clk_i) begin
            if (push[s]) mem_q[wr_ptr_q] <= in_entry[s];
        end

        // Destination mask of every occupied slot, walked from the read pointer.
        always_comb begin
            pend = '0;
            for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
                if (CNT_W'(k) < cnt_q) begin
                    pend[mem_q[rd_ptr_q + PTR_W'(k)].waddr] = 1'b1;
                end
            end
        end
    end

    // MEM wins ties until the ALU has been passed over STARVE_MAX times in a row.
    assign grant_mem   = not_empty[SRC_MEM] &&
                         (!not_empty[SRC_ALU] || (starve_q != STV_W'(STARVE_MAX)));
    assign grant_alu   = not_empty[SRC_ALU] && !grant_mem;
    assign grant_entry = grant_mem ? head[SRC_MEM] : head[SRC_ALU];

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            starve_q <= '0;
        end else if (!not_empty[SRC_ALU] || grant_alu) begin
            starve_q <= '0;
        end else if (grant_mem && (starve_q != STV_W'(STARVE_MAX))) begin
            starve_q <= starve_q + STV_W'(1);
        end
    end

    // Address and data hold their last value when nothing is granted.
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            rf_we_o     <= 1'b0;
            rf_waddr_o  <= '0;
            rf_data_w_o <= '0;
        end else begin
            rf_we_o <= grant_alu || grant_mem;
            if (grant_alu || grant_mem) begin
                rf_waddr_o  <= grant_entry.waddr;
                rf_data_w_o <= grant_entry.data;
            end
        end
    end

    assign pending_o = pend_src[SRC_ALU] | pend_src[SRC_MEM] |
                       (rf_we_o ? (NUM_REGS'(1) << rf_waddr_o) : NUM_REGS'(0));

`ifdef SEGRE_WB_STATS_EN
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            stat_writes_o    <= '0;
            stat_conflicts_o <= '0;
        end else begin
            if (rf_we_o)       stat_writes_o    <= stat_writes_o + 32'(1);
            if (&not_empty)    stat_conflicts_o <= stat_conflicts_o + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_segre_writeback_arbiter.sv
// Directed self-checking bench for segre_writeback_arbiter (default parameters).
module tb_segre_writeback_arbiter;

    logic        clk_i = 1'b0;
    logic        rsn_i;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [4:0]  alu_waddr_i;
    logic [31:0] alu_data_i;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_data_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_data_w_o;
    logic [31:0] pending_o;
`ifdef SEGRE_WB_STATS_EN
    logic [31:0] stat_writes_o;
    logic [31:0] stat_conflicts_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    segre_writeback_arbiter dut (
        .clk_i       (clk_i),
        .rsn_i       (rsn_i),
        .alu_valid_i (alu_valid_i),
        .alu_ready_o (alu_ready_o),
        .alu_waddr_i (alu_waddr_i),
        .alu_data_i  (alu_data_i),
        .mem_valid_i (mem_valid_i),
        .mem_ready_o (mem_ready_o),
        .mem_waddr_i (mem_waddr_i),
        .mem_data_i  (mem_data_i),
        .rf_we_o     (rf_we_o),
        .rf_waddr_o  (rf_waddr_o),
        .rf_data_w_o (rf_data_w_o),
        .pending_o   (pending_o)
`ifdef SEGRE_WB_STATS_EN
        ,
        .stat_writes_o    (stat_writes_o),
        .stat_conflicts_o (stat_conflicts_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance past the next rising edge; everything is driven and sampled here.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rsn_i = 1'b0; alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        alu_waddr_i = '0; alu_data_i = '0; mem_waddr_i = '0; mem_data_i = '0;
        tick(); tick();
        n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", rf_we_o); end
        n_checks++; if (rf_waddr_o !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr_o); end
        n_checks++; if (rf_data_w_o !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", rf_data_w_o); end
        n_checks++; if (pending_o !== 32'd0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", pending_o); end
        n_checks++; if ({alu_ready_o, mem_ready_o} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {alu_ready_o, mem_ready_o}); end
        rsn_i = 1'b1;
        #1;
        n_checks++; if ({alu_ready_o, mem_ready_o} !== 2'b11) begin n_fail++; $display("FAIL idle_ready: got %b want 11", {alu_ready_o, mem_ready_o}); end
        tick();
        n_checks++; if (pending_o !== 32'd0) begin n_fail++; $display("FAIL idle_pending: got %h want 0", pending_o); end
        n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL idle_we: got %0b want 0", rf_we_o); end
    endtask

    task automatic test_single_alu();
        alu_valid_i = 1'b1; alu_waddr_i = 5'd5; alu_data_i = 32'hDEADBEEF;
        tick();
        alu_valid_i = 1'b0;
        n_checks++; if (pending_o !== 32'h0000_0020) begin n_fail++; $display("FAIL single_pend_queued: got %h want 00000020", pending_o); end
        n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL single_we_early: got %0b want 0", rf_we_o); end
        tick();
        n_checks++; if ({rf_we_o, rf_waddr_o, rf_data_w_o} !== {1'b1, 5'd5, 32'hDEADBEEF})
            begin n_fail++; $display("FAIL single_write: got we=%0b a=%0d d=%h want we=1 a=5 d=deadbeef", rf_we_o, rf_waddr_o, rf_data_w_o); end
        n_checks++; if (pending_o !== 32'h0000_0020) begin n_fail++; $display("FAIL single_pend_out: got %h want 00000020", pending_o); end
        tick();
        n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL single_we_after: got %0b want 0", rf_we_o); end
        n_checks++; if (pending_o !== 32'd0) begin n_fail++; $display("FAIL single_pend_clear: got %h want 0", pending_o); end
        n_checks++; if ({rf_waddr_o, rf_data_w_o} !== {5'd5, 32'hDEADBEEF})
            begin n_fail++; $display("FAIL single_hold: got a=%0d d=%h want a=5 d=deadbeef", rf_waddr_o, rf_data_w_o); end
    endtask

    task automatic test_simultaneous();
        alu_valid_i = 1'b1; alu_waddr_i = 5'd3; alu_data_i = 32'h1;
        mem_valid_i = 1'b1; mem_waddr_i = 5'd4; mem_data_i = 32'h2;
        tick();
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        n_checks++; if (pending_o !== 32'h0000_0018) begin n_fail++; $display("FAIL simul_pend: got %h want 00000018", pending_o); end
        tick();
        n_checks++; if ({rf_we_o, rf_waddr_o, rf_data_w_o} !== {1'b1, 5'd4, 32'h2})
            begin n_fail++; $display("FAIL simul_first_mem: got we=%0b a=%0d d=%h want we=1 a=4 d=2", rf_we_o, rf_waddr_o, rf_data_w_o); end
        tick();
        n_checks++; if ({rf_we_o, rf_waddr_o, rf_data_w_o} !== {1'b1, 5'd3, 32'h1})
            begin n_fail++; $display("FAIL simul_second_alu: got we=%0b a=%0d d=%h want we=1 a=3 d=1", rf_we_o, rf_waddr_o, rf_data_w_o); end
        tick();
        n_checks++; if ({rf_we_o, pending_o} !== {1'b0, 32'd0})
            begin n_fail++; $display("FAIL simul_idle: got we=%0b pend=%h want we=0 pend=0", rf_we_o, pending_o); end
    endtask

    // ALU streams to r1, MEM to r2; expected grants MEM,MEM,MEM,ALU repeating.
    task automatic test_starvation();
        int unsigned alu_seq = 0;
        int unsigned mem_seq = 0;
        int unsigned n_wr    = 0;
        logic a_acc, m_acc;
        logic [4:0] exp_addr;
        for (int c = 0; c < 16; c++) begin
            alu_valid_i = 1'b1; alu_waddr_i = 5'd1; alu_data_i = 32'hA000_0000 + alu_seq;
            mem_valid_i = 1'b1; mem_waddr_i = 5'd2; mem_data_i = 32'hB000_0000 + mem_seq;
            a_acc = alu_ready_o; m_acc = mem_ready_o;
            tick();
            if (a_acc) alu_seq++;
            if (m_acc) mem_seq++;
            if (rf_we_o && n_wr < 8) begin
                exp_addr = (n_wr % 4 == 3) ? 5'd1 : 5'd2;
                n_checks++;
                if (rf_waddr_o !== exp_addr) begin n_fail++; $display("FAIL starve_grant%0d: got r%0d want r%0d", n_wr, rf_waddr_o, exp_addr); end
                n_wr++;
            end
        end
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        n_checks++; if (n_wr != 8) begin n_fail++; $display("FAIL starve_count: got %0d writes want 8", n_wr); end
        for (int c = 0; c < 20 && (rf_we_o || pending_o != 0); c++) tick();
        n_checks++; if ({rf_we_o, pending_o} !== {1'b0, 32'd0})
            begin n_fail++; $display("FAIL starve_drain: got we=%0b pend=%h want idle", rf_we_o, pending_o); end
    endtask

    // Checks ALU ready drops at occupancy 2 and every held value is written exactly once, in order.
    task automatic test_backpressure();
        int unsigned alu_seq = 0, mem_seq = 0, alu_wr = 0, mem_wr = 0;
        logic a_acc, m_acc, exp_rdy;
        for (int c = 0; c < 24; c++) begin
            if (c < 14) begin
                alu_valid_i = 1'b1; alu_waddr_i = 5'd1; alu_data_i = 32'hC000_0000 + alu_seq;
                mem_valid_i = 1'b1; mem_waddr_i = 5'd2; mem_data_i = 32'hD000_0000 + mem_seq;
                exp_rdy = (c < 2) ? 1'b1 : ((c - 1) % 4 == 0);
                n_checks++;
                if (alu_ready_o !== exp_rdy) begin n_fail++; $display("FAIL bp_ready_c%0d: got %0b want %0b", c, alu_ready_o, exp_rdy); end
            end else begin
                alu_valid_i = 1'b0; mem_valid_i = 1'b0;
            end
            a_acc = alu_valid_i && alu_ready_o; m_acc = mem_valid_i && mem_ready_o;
            tick();
            if (a_acc) alu_seq++;
            if (m_acc) mem_seq++;
            if (rf_we_o) begin
                n_checks++;
                if (rf_waddr_o == 5'd1) begin
                    if (rf_data_w_o !== 32'hC000_0000 + alu_wr) begin n_fail++; $display("FAIL bp_alu_data%0d: got %h want %h", alu_wr, rf_data_w_o, 32'hC000_0000 + alu_wr); end
                    alu_wr++;
                end else if (rf_waddr_o == 5'd2) begin
                    if (rf_data_w_o !== 32'hD000_0000 + mem_wr) begin n_fail++; $display("FAIL bp_mem_data%0d: got %h want %h", mem_wr, rf_data_w_o, 32'hD000_0000 + mem_wr); end
                    mem_wr++;
                end else begin
                    n_fail++; $display("FAIL bp_addr: got r%0d want r1 or r2", rf_waddr_o);
                end
            end
        end
        n_checks++; if (alu_wr != alu_seq || alu_wr == 0) begin n_fail++; $display("FAIL bp_alu_total: got %0d written want %0d accepted", alu_wr, alu_seq); end
        n_checks++; if (mem_wr != mem_seq || mem_wr == 0) begin n_fail++; $display("FAIL bp_mem_total: got %0d written want %0d accepted", mem_wr, mem_seq); end
        n_checks++; if ({rf_we_o, pending_o} !== {1'b0, 32'd0})
            begin n_fail++; $display("FAIL bp_drain: got we=%0b pend=%h want idle", rf_we_o, pending_o); end
    endtask

    task automatic test_x0_reset();
        mem_valid_i = 1'b1; mem_waddr_i = 5'd0; mem_data_i = 32'h55;
        n_checks++; if (mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %0b want 1", mem_ready_o); end
        tick();
        mem_valid_i = 1'b0;
        n_checks++; if (pending_o !== 32'd0) begin n_fail++; $display("FAIL x0_pending: got %h want 0", pending_o); end
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL x0_we_c%0d: got %0b want 0", c, rf_we_o); end
            tick();
        end
        alu_valid_i = 1'b1; alu_waddr_i = 5'd6; alu_data_i = 32'h66;
        mem_valid_i = 1'b1; mem_waddr_i = 5'd7; mem_data_i = 32'h77;
        tick();
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        rsn_i = 1'b0;
        #1;
        n_checks++; if (pending_o !== 32'h0000_00C0) begin n_fail++; $display("FAIL rst_pend_before: got %h want 000000c0", pending_o); end
        n_checks++; if ({alu_ready_o, mem_ready_o} !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b want 00", {alu_ready_o, mem_ready_o}); end
        tick();
        rsn_i = 1'b1;
        n_checks++; if (pending_o !== 32'd0) begin n_fail++; $display("FAIL rst_pend_after: got %h want 0", pending_o); end
        n_checks++; if ({rf_we_o, rf_waddr_o, rf_data_w_o} !== {1'b0, 5'd0, 32'd0})
            begin n_fail++; $display("FAIL rst_outputs: got we=%0b a=%0d d=%h want all 0", rf_we_o, rf_waddr_o, rf_data_w_o); end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if ({rf_we_o, pending_o} !== {1'b0, 32'd0})
                begin n_fail++; $display("FAIL rst_no_write_c%0d: got we=%0b pend=%h want idle", c, rf_we_o, pending_o); end
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_simultaneous();
        test_starvation();
        test_backpressure();
        test_x0_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
